bus_controller: RTL
===================

# bus_controller

Control sequencer for the 10-bit processor's dual-bus register file. It accepts one instruction per `Exec` request and walks a small state machine. Each cycle it drives the per-register `Rin`/`Rout0`/`Rout1` enables, the external-data bus driver, and the ALU result register (G) controls. At most one tri-state driver is enabled on each bus in any cycle.

## Interface
- `NREG`, default 4: number of general registers. This is fixed at 4 by the 2-bit register fields; other values are unsupported.

Ports:
- `CLKb` in 1: system clock. The controller updates on the rising edge, and the register file captures on the falling edge.
- `Resetb` in 1: reset, one clock, synchronous active-low.
- `Exec` in 1: start request, sampled only in IDLE.
- `INSTR` in 10: instruction word, captured into IR when `Exec` is accepted.
  - [9:7] opcode
  - [6:5] Rx
  - [4:3] Ry
  - [2:0] reserved, ignored
- `Rin` out NREG: one-hot register load enables.
- `Rout0` out NREG: one-hot enables, register onto bus 0.
- `Rout1` out NREG: one-hot enables, register onto bus 1.
- `ExtOut` out 1: drives external `DIN` onto bus 0.
- `Gin` out 1: ALU result register load enable.
- `Gout` out 1: G register onto bus 0.
- `AddSub` out 1: ALU function, 0 = add, 1 = subtract.
- `Busy` out 1: high while an instruction is executing.
- `Done` out 1: single-cycle pulse in the final execution cycle.
- `Err` out 1: pulses with `Done` for an illegal opcode.

## Operation
Opcodes:
- 000 LOAD: Rx ← DIN
- 001 MOV: Rx ← Ry
- 010 ADD: Rx ← Rx + Ry
- 011 SUB: Rx ← Rx − Ry
- 100–111: illegal

States:
- **IDLE**
  - All outputs are 0.
  - `Exec`=1 at a rising edge latches IR ← INSTR and moves to T1.
  - `Exec`=0 stays in IDLE.
- **T1**
  - LOAD: `ExtOut`=1, `Rin[Rx]`=1, `Done`=1. Next state is IDLE.
  - MOV: `Rout0[Ry]`=1, `Rin[Rx]`=1, `Done`=1. Next state is IDLE.
  - ADD/SUB: `Rout0[Rx]`=1, `Rout1[Ry]`=1, `Gin`=1, `AddSub`=opcode[0]. Next state is T2.
  - Illegal: `Done`=1, `Err`=1, no enables asserted. Next state is IDLE.
- **T2** (ADD/SUB only): `Gout`=1, `Rin[Rx]`=1, `Done`=1. Next state is IDLE.

Output and encoding rules:
- Outputs are decoded only from the state register and IR, and are glitch-free relative to the falling capture edge.
- `Busy` = (state ≠ IDLE).
- `Rin`, `Rout0` and `Rout1` are each all-zero or one-hot.
- Bus 0 drivers (`Rout0` bits, `ExtOut`, `Gout`) are mutually exclusive.
- Bus 1 has at most one `Rout1` bit set.

Boundary conditions:
- `Exec` is ignored while `Busy`=1. Changes to `INSTR` after acceptance have no effect because IR holds the instruction.
- `Exec` held high continuously: a new instruction is accepted on the first rising edge spent in IDLE. This gives back-to-back issue with exactly one IDLE cycle between instructions.
- MOV with Rx=Ry is legal: `Rout0[Rx]` and `Rin[Rx]` are asserted in the same cycle.
- ADD/SUB with Rx=Ry is legal. SUB yields 0.
- Reserved bits [2:0] have no effect.

Reset:
- `Resetb`=0 at a rising edge forces state=IDLE and IR=0.
- Every output reads 0 in the following cycle: `Busy`=0, `Done`=0, `Err`=0, and all enables 0.
- Reset in T1 or T2 aborts the instruction. No further `Rin` is asserted, and the register contents are whatever the last falling edge captured.

## Timing
- Accept edge is E0. Outputs for T1 are valid from E0 until E1.
  - The register file captures at the falling edge between E0 and E1.
  - LOAD, MOV and illegal opcodes: `Done` and `Busy` drop at E1.
- ADD/SUB: `Gin` captures at the falling edge in T1. T2 is valid from E1 to E2, and Rx captures at the falling edge in T2.
- Latency from the accept edge to the last write:
  - LOAD, MOV: 1 cycle
  - ADD, SUB: 2 cycles
  - Illegal: 1 cycle
- `Done` is high for exactly one cycle per accepted instruction and never while IDLE.

## Test plan
- **LOAD/MOV:** reset, then LOAD R2 with DIN=0x15A.
  - Expect T1 `ExtOut`=1, `Rin`=0100, `Done`=1, then IDLE.
  - Then MOV R0←R2 expects `Rout0`=0100, `Rin`=0001, and R0=0x15A.
- **ADD:** R1=0x003, R3=0x005, ADD R1,R3.
  - T1: `Rout0`=0010, `Rout1`=1000, `Gin`=1, `AddSub`=0.
  - T2: `Gout`=1, `Rin`=0010, `Done`=1.
  - R1=0x008.
- **SUB wrap:** R0=0x000, R1=0x001, SUB R0,R1.
  - `AddSub`=1 in T1.
  - R0=0x3FF (10-bit wrap).
- **Busy/illegal:** `Exec` held high; ADD, then opcode 101.
  - `Exec` is ignored during T1 and T2.
  - After one IDLE cycle, the 101 instruction gives `Done`=1, `Err`=1, all enables 0.
- **Reset mid-op:** `Resetb`=0 during T1 of SUB.
  - Next cycle: state IDLE, all outputs 0, no T2 write.
  - The subsequent `Exec` executes normally.
- **Exclusivity check (every cycle):**
  - At most one bus 0 driver asserted.
  - `popcount(Rout1)` ≤ 1.
  - `popcount(Rin)` ≤ 1.
  - `Done` ≤ one per accepted `Exec`.

Source files
------------

// File: rtl/bus_controller_if.sv
// Handshake and enable bundle between the bus_controller sequencer and the
// dual-bus register file / ALU datapath it steers.
interface bus_controller_if #(
    parameter int NREG = 4
);
    logic            Exec;
    logic [9:0]      INSTR;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout0;
    logic [NREG-1:0] Rout1;
    logic            ExtOut;
    logic            Gin;
    logic            Gout;
    logic            AddSub;
    logic            Busy;
    logic            Done;
    logic            Err;

    modport master (
        input  Exec, INSTR,
        output Rin, Rout0, Rout1, ExtOut, Gin, Gout, AddSub, Busy, Done, Err
    );

    modport slave (
        output Exec, INSTR,
        input  Rin, Rout0, Rout1, ExtOut, Gin, Gout, AddSub, Busy, Done, Err
    );
endinterface

// File: rtl/bus_controller.sv
// Control sequencer for the 10-bit dual-bus register file: accepts one
// instruction per Exec in IDLE and steps IDLE -> T1 (-> T2) -> IDLE.
module bus_controller #(
    parameter int NREG = 4
) (
    input  logic             CLKb,
    input  logic             Resetb,
    bus_controller_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;

    typedef struct packed {
        logic [NREG-1:0] rin;
        logic [NREG-1:0] rout0;
        logic [NREG-1:0] rout1;
        logic            ext_out;
        logic            gin;
        logic            gout;
        logic            add_sub;
        logic            busy;
        logic            done;
        logic            err;
    } ctrl_t;

    // IR keeps only {opcode, Rx, Ry}; the reserved bits never enter the state.
    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_ir;
    logic [6:0]  w_ir_nxt;
    ctrl_t       r_ctrl;
    ctrl_t       w_ctrl_nxt;
    logic        w_unused_rsvd;

    assign w_unused_rsvd = ^bus.INSTR[2:0];

    function automatic logic [NREG-1:0] sel_onehot(input logic [1:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st, input logic [6:0] ir);
        ctrl_t      c;
        logic [2:0] opc;
        logic [1:0] rx;
        logic [1:0] ry;
        c   = '0;
        opc = ir[6:4];
        rx  = ir[3:2];
        ry  = ir[1:0];
        case (st)
            S_T1: begin
                c.busy = 1'b1;
                case (opc)
                    OP_LOAD: begin
                        c.ext_out = 1'b1;
                        c.rin     = sel_onehot(rx);
                        c.done    = 1'b1;
                    end
                    OP_MOV: begin
                        c.rout0 = sel_onehot(ry);
                        c.rin   = sel_onehot(rx);
                        c.done  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        c.rout0   = sel_onehot(rx);
                        c.rout1   = sel_onehot(ry);
                        c.gin     = 1'b1;
                        c.add_sub = opc[0];
                    end
                    default: begin
                        c.done = 1'b1;
                        c.err  = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                c.busy = 1'b1;
                c.gout = 1'b1;
                c.rin  = sel_onehot(rx);
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next state and IR; outputs are decoded from them so they can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE: begin
                if (bus.Exec) begin
                    w_state_nxt = S_T1;
                    w_ir_nxt    = bus.INSTR[9:3];
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_T1: begin
                if ((r_ir[6:4] == OP_ADD) || (r_ir[6:4] == OP_SUB)) begin
                    w_state_nxt = S_T2;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_T2: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ctrl_nxt = decode_ctrl(w_state_nxt, w_ir_nxt);
    end

    // State, IR and output registers; outputs change only on the rising edge.
    always_ff @(posedge CLKb) begin
        if (!Resetb) begin
            r_state <= S_IDLE;
            r_ir    <= 7'd0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    assign bus.Rin    = r_ctrl.rin;
    assign bus.Rout0  = r_ctrl.rout0;
    assign bus.Rout1  = r_ctrl.rout1;
    assign bus.ExtOut = r_ctrl.ext_out;
    assign bus.Gin    = r_ctrl.gin;
    assign bus.Gout   = r_ctrl.gout;
    assign bus.AddSub = r_ctrl.add_sub;
    assign bus.Busy   = r_ctrl.busy;
    assign bus.Done   = r_ctrl.done;
    assign bus.Err    = r_ctrl.err;
endmodule
